// File: rtl/pong_pkg.sv
// Shared types and default parameters for the pong game-flow sequencer.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SERVE,
      ST_RALLY,
      ST_POINT,
      ST_OVER
   } pong_state_e;

   localparam int SCORE_BITS_DEF   = 3;
   localparam int WIN_SCORE_DEF    = 7;
   localparam int SERVE_FRAMES_DEF = 60;
   localparam int POINT_FRAMES_DEF = 30;

   // Frame counter must hold the longer of the two intervals.
   function automatic int frame_cnt_width(input int serve_frames, input int point_frames);
      int longest;
      longest = (serve_frames > point_frames) ? serve_frames : point_frames;
      return $clog2(longest + 1);
   endfunction

   localparam int FRAME_CNT_W_DEF = frame_cnt_width(SERVE_FRAMES_DEF, POINT_FRAMES_DEF);

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-tick down-counter: load sets the interval, done pulses on the tick
// that takes the count from 1 to 0.
module pong_frame_timer #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             frame_tick,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load wins over a coincident tick, so a tick in the load cycle is not counted.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (frame_tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create simulation/synthesis mismatches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = frame_tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: serve/rally/point timing, scores and game over.
// Optional attract (demo) play in IDLE is enabled by defining PONG_ATTRACT_EN.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int SCORE_BITS   = SCORE_BITS_DEF,
   parameter int WIN_SCORE    = WIN_SCORE_DEF,
   parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
   parameter int POINT_FRAMES = POINT_FRAMES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_tick,
   input  logic                  start,
   input  logic                  score_reset,
   input  logic                  miss_l,
   input  logic                  miss_r,
   output logic                  ball_run,
   output logic                  ball_load,
   output logic                  serve_left,
   output logic [SCORE_BITS-1:0] score_l,
   output logic [SCORE_BITS-1:0] score_r,
   output logic                  game_over,
   output logic                  winner_left
);

   localparam int                    CNT_W    = frame_cnt_width(SERVE_FRAMES, POINT_FRAMES);
   localparam logic [SCORE_BITS-1:0] WIN_VAL  = SCORE_BITS'(WIN_SCORE);
   localparam logic [CNT_W-1:0]      SERVE_LD = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0]      POINT_LD = CNT_W'(POINT_FRAMES);

   pong_state_e state_q, state_d;

   logic                  start_q;
   logic                  ball_run_q, ball_run_d;
   logic                  ball_load_q, ball_load_d;
   logic                  serve_left_q, serve_left_d;
   logic [SCORE_BITS-1:0] score_l_q, score_l_d;
   logic [SCORE_BITS-1:0] score_r_q, score_r_d;
   logic                  game_over_q, game_over_d;
   logic                  winner_left_q, winner_left_d;

   logic                  start_rise;
   logic                  new_game;
   logic                  right_pt;
   logic                  left_pt;
   logic [SCORE_BITS-1:0] score_l_inc;
   logic [SCORE_BITS-1:0] score_r_inc;
   logic                  timer_load;
   logic [CNT_W-1:0]      timer_val;
   logic                  timer_done;

   assign start_rise = start && !start_q;
   assign new_game   = start_rise && ((state_q == ST_IDLE) || (state_q == ST_OVER));

   // A miss on the left paddle scores for the right; miss_l wins a tie.
   assign right_pt = (state_q == ST_RALLY) && miss_l;
   assign left_pt  = (state_q == ST_RALLY) && miss_r && !miss_l;

   assign score_l_inc = (score_l_q == WIN_VAL) ? score_l_q : score_l_q + SCORE_BITS'(1);
   assign score_r_inc = (score_r_q == WIN_VAL) ? score_r_q : score_r_q + SCORE_BITS'(1);

   pong_frame_timer #(
      .CNT_W(CNT_W)
   ) u_frame_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (timer_load),
      .load_val  (timer_val),
      .frame_tick(frame_tick),
      .done      (timer_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (score_reset) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_OVER: if (start_rise) state_d = ST_SERVE;
            ST_SERVE:         if (timer_done) state_d = ST_RALLY;
            ST_RALLY: begin
               if (right_pt) begin
                  state_d = (score_r_inc == WIN_VAL) ? ST_OVER : ST_POINT;
               end else if (left_pt) begin
                  state_d = (score_l_inc == WIN_VAL) ? ST_OVER : ST_POINT;
               end
            end
            ST_POINT:         if (timer_done) state_d = ST_SERVE;
            default:          state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ball_load_d   = 1'b0;
      serve_left_d  = serve_left_q;
      score_l_d     = score_l_q;
      score_r_d     = score_r_q;
      winner_left_d = winner_left_q;
      timer_load    = 1'b0;
      timer_val     = '0;

      if (score_reset) begin
         score_l_d     = '0;
         score_r_d     = '0;
         winner_left_d = 1'b0;
         timer_load    = 1'b1;
      end else if (new_game) begin
         score_l_d     = '0;
         score_r_d     = '0;
         winner_left_d = 1'b0;
         ball_load_d   = 1'b1;
         timer_load    = 1'b1;
         timer_val     = SERVE_LD;
`ifdef PONG_ATTRACT_EN
      end else if ((state_q == ST_IDLE) && (miss_l || miss_r)) begin
         ball_load_d  = 1'b1;
         serve_left_d = !serve_left_q;
`endif
      end else if (right_pt) begin
         score_r_d    = score_r_inc;
         serve_left_d = 1'b0;
         if (score_r_inc == WIN_VAL) begin
            winner_left_d = 1'b0;
         end else begin
            timer_load = 1'b1;
            timer_val  = POINT_LD;
         end
      end else if (left_pt) begin
         score_l_d    = score_l_inc;
         serve_left_d = 1'b1;
         if (score_l_inc == WIN_VAL) begin
            winner_left_d = 1'b1;
         end else begin
            timer_load = 1'b1;
            timer_val  = POINT_LD;
         end
      end else if ((state_q == ST_POINT) && timer_done) begin
         ball_load_d = 1'b1;
         timer_load  = 1'b1;
         timer_val   = SERVE_LD;
      end

      ball_run_d  = (state_d == ST_RALLY);
`ifdef PONG_ATTRACT_EN
      ball_run_d  = ball_run_d || ((state_d == ST_IDLE) && !score_reset);
`endif
      game_over_d = (state_d == ST_OVER);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q       <= 1'b0;
         ball_run_q    <= 1'b0;
         ball_load_q   <= 1'b0;
         serve_left_q  <= 1'b0;
         score_l_q     <= '0;
         score_r_q     <= '0;
         game_over_q   <= 1'b0;
         winner_left_q <= 1'b0;
      end else begin
         start_q       <= start;
         ball_run_q    <= ball_run_d;
         ball_load_q   <= ball_load_d;
         serve_left_q  <= serve_left_d;
         score_l_q     <= score_l_d;
         score_r_q     <= score_r_d;
         game_over_q   <= game_over_d;
         winner_left_q <= winner_left_d;
      end
   end

   assign ball_run    = ball_run_q;
   assign ball_load   = ball_load_q;
   assign serve_left  = serve_left_q;
   assign score_l     = score_l_q;
   assign score_r     = score_r_q;
   assign game_over   = game_over_q;
   assign winner_left = winner_left_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed vector table, multi-cycle
// game sequences and randomized play against a frame-counting game model.
module tb_pong_game_ctrl;

   localparam int SB  = 3;
   localparam int WIN = 7;
   localparam int SF  = 60;
   localparam int PF  = 30;
`ifdef PONG_ATTRACT_EN
   localparam int ATTRACT = 1;
`else
   localparam int ATTRACT = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_tick = 1'b0;
   logic          start = 1'b0;
   logic          score_reset = 1'b0;
   logic          miss_l = 1'b0;
   logic          miss_r = 1'b0;
   logic          ball_run, ball_load, serve_left, game_over, winner_left;
   logic [SB-1:0] score_l, score_r;

   pong_game_ctrl #(
      .SCORE_BITS  (SB),
      .WIN_SCORE   (WIN),
      .SERVE_FRAMES(SF),
      .POINT_FRAMES(PF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .start      (start),
      .score_reset(score_reset),
      .miss_l     (miss_l),
      .miss_r     (miss_r),
      .ball_run   (ball_run),
      .ball_load  (ball_load),
      .serve_left (serve_left),
      .score_l    (score_l),
      .score_r    (score_r),
      .game_over  (game_over),
      .winner_left(winner_left)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Game model: phases and frames-remaining counted with plain integers.
   typedef enum int {M_IDLE, M_SERVE, M_RALLY, M_POINT, M_OVER} mphase_e;
   mphase_e m_phase;
   int m_left, m_sl, m_sr, m_srv, m_win, m_load, m_run, m_start_prev;

   task automatic model_reset();
      m_phase = M_IDLE; m_left = 0; m_sl = 0; m_sr = 0; m_srv = 0;
      m_win = 0; m_load = 0; m_run = 0; m_start_prev = 0;
   endtask

   task automatic model_new_game();
      m_phase = M_SERVE; m_left = SF; m_sl = 0; m_sr = 0; m_win = 0; m_load = 1;
   endtask

   task automatic model_step();
      int rise;
      rise = (start && !m_start_prev) ? 1 : 0;
      m_start_prev = start;
      m_load = 0;
      if (score_reset) begin
         m_phase = M_IDLE; m_sl = 0; m_sr = 0; m_win = 0; m_left = 0;
      end else begin
         case (m_phase)
            M_IDLE: begin
               if (rise != 0) model_new_game();
               else if (ATTRACT != 0 && (miss_l || miss_r)) begin
                  m_load = 1; m_srv = 1 - m_srv;
               end
            end
            M_OVER: if (rise != 0) model_new_game();
            M_SERVE: if (frame_tick) begin
               m_left--;
               if (m_left == 0) m_phase = M_RALLY;
            end
            M_RALLY: begin
               if (miss_l) begin
                  if (m_sr < WIN) m_sr++;
                  m_srv = 0;
                  if (m_sr == WIN) m_phase = M_OVER;
                  else begin m_phase = M_POINT; m_left = PF; end
               end else if (miss_r) begin
                  if (m_sl < WIN) m_sl++;
                  m_srv = 1;
                  if (m_sl == WIN) begin m_phase = M_OVER; m_win = 1; end
                  else begin m_phase = M_POINT; m_left = PF; end
               end
            end
            M_POINT: if (frame_tick) begin
               m_left--;
               if (m_left == 0) begin m_phase = M_SERVE; m_left = SF; m_load = 1; end
            end
            default: m_phase = M_IDLE;
         endcase
      end
      m_run = (m_phase == M_RALLY || (ATTRACT != 0 && m_phase == M_IDLE && !score_reset)) ? 1 : 0;
   endtask

   task automatic check_model();
      check("model_ball_run",    ball_run,    m_run);
      check("model_ball_load",   ball_load,   m_load);
      check("model_serve_left",  serve_left,  m_srv);
      check("model_score_l",     score_l,     m_sl);
      check("model_score_r",     score_r,     m_sr);
      check("model_game_over",   game_over,   (m_phase == M_OVER) ? 1 : 0);
      check("model_winner_left", winner_left, m_win);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic run_ticks(input int n);
      repeat (n) begin
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
      end
   endtask

   typedef struct {
      int start, srst, tick, ml, mr, pre;
      int run, load, srv, scl, scr, over, win;
   } vec_t;

   vec_t vecs[18];

   initial begin
      vecs = '{
         '{1,0,0,0,0,0,  0,1,0,0,0,0,0},        // start rise -> SERVE, load pulse
         '{1,0,0,0,0,0,  0,0,0,0,0,0,0},        // held start: no retrigger, pulse ends
         '{1,0,0,0,0,59, 0,0,0,0,0,0,0},        // 59 ticks: not yet running
         '{1,0,1,0,0,0,  1,0,0,0,0,0,0},        // 60th tick -> RALLY
         '{1,0,0,1,0,0,  0,0,0,0,1,0,0},        // miss_l: right scores
         '{1,0,1,0,0,29, 0,1,0,0,1,0,0},        // 30 ticks: re-serve pulse
         '{1,0,0,0,0,0,  0,0,0,0,1,0,0},
         '{1,0,1,0,0,59, 1,0,0,0,1,0,0},        // 60 ticks: running again
         '{1,0,0,0,1,0,  0,0,1,1,1,0,0},        // miss_r: left scores, left serves
         '{1,0,1,0,0,29, 0,1,1,1,1,0,0},
         '{1,0,1,0,0,59, 1,0,1,1,1,0,0},
         '{1,0,0,1,1,0,  0,0,0,1,2,0,0},        // simultaneous misses: miss_l wins
         '{1,0,0,1,0,0,  0,0,0,1,2,0,0},        // miss during POINT ignored
         '{1,1,0,0,1,0,  0,0,0,0,0,0,0},        // score_reset beats miss
         '{0,0,0,0,0,0,  ATTRACT,0,0,0,0,0,0},  // IDLE
         '{1,0,1,0,0,0,  0,1,0,0,0,0,0},        // start with coincident tick
         '{1,0,0,0,0,59, 0,0,0,0,0,0,0},        // coincident tick was not counted
         '{1,0,1,0,0,0,  1,0,0,0,0,0,0}
      };

      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check("reset_ball_run",    ball_run,    0);
      check("reset_ball_load",   ball_load,   0);
      check("reset_serve_left",  serve_left,  0);
      check("reset_score_l",     score_l,     0);
      check("reset_score_r",     score_r,     0);
      check("reset_game_over",   game_over,   0);
      check("reset_winner_left", winner_left, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();

      foreach (vecs[i]) begin
         start = vecs[i].start[0];
         run_ticks(vecs[i].pre);
         score_reset = vecs[i].srst[0];
         frame_tick  = vecs[i].tick[0];
         miss_l      = vecs[i].ml[0];
         miss_r      = vecs[i].mr[0];
         step();
         score_reset = 1'b0; frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
         check($sformatf("vec%0d_ball_run", i),    ball_run,    vecs[i].run);
         check($sformatf("vec%0d_ball_load", i),   ball_load,   vecs[i].load);
         check($sformatf("vec%0d_serve_left", i),  serve_left,  vecs[i].srv);
         check($sformatf("vec%0d_score_l", i),     score_l,     vecs[i].scl);
         check($sformatf("vec%0d_score_r", i),     score_r,     vecs[i].scr);
         check($sformatf("vec%0d_game_over", i),   game_over,   vecs[i].over);
         check($sformatf("vec%0d_winner_left", i), winner_left, vecs[i].win);
      end

      // Left wins 7-0 with start held high the whole game.
      for (int p = 1; p <= WIN; p++) begin
         miss_r = 1'b1; step(); miss_r = 1'b0;
         check($sformatf("win_seq_score_l_%0d", p), score_l, p);
         check($sformatf("win_seq_serve_left_%0d", p), serve_left, 1);
         if (p < WIN) begin
            run_ticks(PF);
            run_ticks(SF);
            check($sformatf("win_seq_rally_%0d", p), ball_run, 1);
         end
      end
      check("over_game_over",   game_over,   1);
      check("over_winner_left", winner_left, 1);
      check("over_score_l",     score_l,     WIN);
      check("over_ball_run",    ball_run,    0);
      miss_r = 1'b1; step(); miss_r = 1'b0;
      miss_l = 1'b1; step(); miss_l = 1'b0;
      check("over_frozen_score_l", score_l, WIN);
      check("over_frozen_score_r", score_r, 0);
      repeat (10) step();
      check("over_start_held", game_over, 1);
      start = 1'b0; step();
      check("over_start_low", game_over, 1);
      start = 1'b1; step();
      check("restart_ball_load",   ball_load,   1);
      check("restart_game_over",   game_over,   0);
      check("restart_winner_left", winner_left, 0);
      check("restart_score_l",     score_l,     0);

      // Asynchronous reset in the middle of a rally.
      run_ticks(SF);
      miss_r = 1'b1; step(); miss_r = 1'b0;
      run_ticks(PF);
      run_ticks(SF);
      check("pre_rst_ball_run", ball_run, 1);
      check("pre_rst_score_l",  score_l,  1);
      start = 1'b0; step();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ball_run",    ball_run,    0);
      check("async_rst_ball_load",   ball_load,   0);
      check("async_rst_serve_left",  serve_left,  0);
      check("async_rst_score_l",     score_l,     0);
      check("async_rst_score_r",     score_r,     0);
      check("async_rst_game_over",   game_over,   0);
      check("async_rst_winner_left", winner_left, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Randomized play.
      for (int c = 0; c < 20000; c++) begin
         if ($urandom_range(0, 49) == 0) start = ~start;
         score_reset = ($urandom_range(0, 2999) == 0);
         frame_tick  = ($urandom_range(0, 2) == 0);
         miss_l      = ($urandom_range(0, 15) == 0);
         miss_r      = ($urandom_range(0, 15) == 0);
         step();
      end
      score_reset = 1'b0; frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
